// File: rtl/adpcm_decoder.sv
// ============================================================================
// Module   : adpcm_decoder
// Purpose  : IMA ADPCM 4-bit code to 16-bit signed PCM decoder, 3 clocks/code.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adpcm_decoder #(
    parameter logic signed [15:0] PRED_INIT  = 16'sd0,
    parameter logic        [6:0]  INDEX_INIT = 7'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [3:0]  code_in,
    input  logic        code_valid,
    output logic        code_ready,
    output logic [15:0] pcm_out,
    output logic        pcm_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_ACC  = 2'd2
    } state_t;

    localparam logic [6:0] INDEX_MAX = 7'd88;

    localparam logic [15:0] STEP_TABLE [0:88] = '{
        16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
        16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
        16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
        16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
        16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
        16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
        16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
        16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
        16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
        16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
        16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
        16'd32767
    };

    state_t             state_q, state_d;
    logic [3:0]         code_q, code_d;
    logic [15:0]        step_q, step_d;
    logic signed [15:0] pred_q, pred_d;
    logic [6:0]         index_q, index_d;
    logic               pcm_valid_q, pcm_valid_d;

    logic [16:0]        diff;
    logic signed [17:0] sum;
    logic signed [15:0] sum_sat;
    logic signed [7:0]  index_adj;
    logic signed [7:0]  index_sum;
    logic [6:0]         index_clamped;

    assign code_ready = (state_q == ST_IDLE) && !clear;
    assign pcm_out    = pred_q;
    assign pcm_valid  = pcm_valid_q;

    always_comb begin
        diff = {4'd0, step_q[15:3]};
        if (code_q[2]) diff = diff + {1'b0, step_q};
        if (code_q[1]) diff = diff + {2'd0, step_q[15:1]};
        if (code_q[0]) diff = diff + {3'd0, step_q[15:2]};

        if (code_q[3]) sum = {{2{pred_q[15]}}, pred_q} - $signed({1'b0, diff});
        else           sum = {{2{pred_q[15]}}, pred_q} + $signed({1'b0, diff});

        if (sum > 18'sd32767)       sum_sat = 16'sh7FFF;
        else if (sum < -18'sd32768) sum_sat = 16'sh8000;
        else                        sum_sat = sum[15:0];
    end

    // Signed 8-bit index math lets 0-1 and 88+8 clamp without wrapping.
    always_comb begin
        case (code_q[2:0])
            3'd4:    index_adj = 8'sd2;
            3'd5:    index_adj = 8'sd4;
            3'd6:    index_adj = 8'sd6;
            3'd7:    index_adj = 8'sd8;
            default: index_adj = -8'sd1;
        endcase
        index_sum = $signed({1'b0, index_q}) + index_adj;
        if (index_sum < 8'sd0)                            index_clamped = 7'd0;
        else if (index_sum > $signed({1'b0, INDEX_MAX})) index_clamped = INDEX_MAX;
        else                                              index_clamped = index_sum[6:0];
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        step_d      = step_q;
        pred_d      = pred_q;
        index_d     = index_q;
        pcm_valid_d = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            pred_d  = PRED_INIT;
            index_d = INDEX_INIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (code_valid) begin
                        code_d  = code_in;
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    step_d  = (index_q > INDEX_MAX) ? 16'd32767 : STEP_TABLE[index_q];
                    state_d = ST_ACC;
                end
                ST_ACC: begin
                    pred_d      = sum_sat;
                    index_d     = index_clamped;
                    pcm_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            code_q      <= 4'd0;
            step_q      <= 16'd0;
            pred_q      <= PRED_INIT;
            index_q     <= INDEX_INIT;
            pcm_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            step_q      <= step_d;
            pred_q      <= pred_d;
            index_q     <= index_d;
            pcm_valid_q <= pcm_valid_d;
        end
    end

endmodule

`default_nettype wire
